// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard controller.
package hazard_ctrl_pkg;

    // Register specifier width (32 architectural registers).
    localparam int REG_SIZE = 5;

    // Default occupancy / timeout values; the top exposes them as parameters.
    localparam int DEF_MUL_LAT     = 4;
    localparam int DEF_DIV_LAT     = 32;
    localparam int DEF_MEM_TIMEOUT = 255;

    // HI/LO occupancy state: IDLE means HI/LO holds a valid result.
    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mduState_t;

endpackage

// File: rtl/hazard_ctrl_mdu_busy_counter.sv
// Tracks how long a MULT/DIV keeps HI/LO busy after it issues from EX.
// The state is registered and exported so HI/LO occupancy can be observed directly.
module hazard_ctrl_mdu_busy_counter
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = DEF_MUL_LAT,
    parameter int DIV_LAT = DEF_DIV_LAT
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      start,
    input  logic      isDiv,
    output mduState_t state
);

    localparam int CNT_W = $clog2(DIV_LAT + 1);
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LAT - 1);

    logic [CNT_W-1:0] mduCnt;

    // Load on issue, count down to zero, then drop back to IDLE one cycle later.
    // A start seen while BUSY simply reloads the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= MDU_IDLE;
            mduCnt <= '0;
        end else if (start) begin
            state  <= MDU_BUSY;
            mduCnt <= isDiv ? DIV_LOAD : MUL_LOAD;
        end else if (mduCnt != '0) begin
            mduCnt <= mduCnt - 1'b1;
        end else begin
            state <= MDU_IDLE;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS pipeline: generates stall/flush for the
// IF/ID, ID/EX and EX/MEM registers and tracks HI/LO and data-memory wait state.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT     = DEF_MUL_LAT,
    parameter int DIV_LAT     = DEF_DIV_LAT,
    parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] rsD,
    input  logic [4:0] rtD,
    input  logic       useRsD,
    input  logic       useRtD,
    input  logic       branchD,
    input  logic       takenD,
    input  logic       hiloUseD,
    input  logic       regWriteE,
    input  logic       memToRegE,
    input  logic [4:0] writeRegE,
    input  logic       memToRegM,
    input  logic [4:0] writeRegM,
    input  logic       mduStartE,
    input  logic       mduIsDivE,
    input  logic       memReqM,
    input  logic       dmemReadyM,
    output logic       stallF,
    output logic       stallD,
    output logic       stallE,
    output logic       stallM,
    output logic       flushD,
    output logic       flushE,
    output logic       mduBusy,
    output logic       memTimeout
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] TIMEOUT_CNT = WAIT_W'(MEM_TIMEOUT);

    logic              memStall;
    logic              srcMatchE;
    logic              srcMatchM;
    logic              loadUse;
    logic              branchStall;
    logic              hiloStall;
    logic [WAIT_W-1:0] waitCnt;
    mduState_t         mduState;

    // Hazard detection; $0 destinations never match.
    always_comb begin
        memStall    = memReqM & ~dmemReadyM;
        srcMatchE   = (writeRegE != 5'd0) &
                      ((useRsD & (rsD == writeRegE)) | (useRtD & (rtD == writeRegE)));
        srcMatchM   = (writeRegM != 5'd0) &
                      ((useRsD & (rsD == writeRegM)) | (useRtD & (rtD == writeRegM)));
        loadUse     = memToRegE & regWriteE & srcMatchE;
        branchStall = branchD & ((regWriteE & srcMatchE) | (memToRegM & srcMatchM));
        hiloStall   = hiloUseD & (mduBusy | mduStartE);
    end

    // Stall/flush priority: reset bubble, then memory freeze, then D-stage hazards.
    always_comb begin
        stallF = 1'b0;
        stallD = 1'b0;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = 1'b0;
        flushE = 1'b0;
        if (!rst) begin
            flushD = 1'b1;
            flushE = 1'b1;
        end else if (memStall) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
        end else if (loadUse | branchStall | hiloStall) begin
            // The stalled branch stays in D, so its redirect is deferred.
            stallF = 1'b1;
            stallD = 1'b1;
            flushE = 1'b1;
        end else begin
            flushD = takenD;
        end
    end

    // An op held in EX by a memory freeze has not issued yet.
    hazard_ctrl_mdu_busy_counter #(
        .MUL_LAT (MUL_LAT),
        .DIV_LAT (DIV_LAT)
    ) uMduBusy (
        .clk   (clk),
        .rst   (rst),
        .start (mduStartE & ~stallE),
        .isDiv (mduIsDivE),
        .state (mduState)
    );

    // HI/LO busy flag straight from the registered occupancy state.
    always_comb begin
        mduBusy = (mduState == MDU_BUSY);
    end

    // Count consecutive dmem wait cycles; the timeout flag is sticky until reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            waitCnt    <= '0;
            memTimeout <= 1'b0;
        end else begin
            if (waitCnt == TIMEOUT_CNT) begin
                memTimeout <= 1'b1;
            end
            if (memStall) begin
                if (waitCnt != '1) begin
                    waitCnt <= waitCnt + 1'b1;
                end
            end else begin
                waitCnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random traffic,
// each cycle compared against a reference model built from the pipeline rules.
module tb_hazard_ctrl;

    localparam int MUL_LAT     = 4;
    localparam int DIV_LAT     = 32;
    localparam int MEM_TIMEOUT = 255;

    logic       clk;
    logic       rst;
    logic [4:0] rsD;
    logic [4:0] rtD;
    logic       useRsD;
    logic       useRtD;
    logic       branchD;
    logic       takenD;
    logic       hiloUseD;
    logic       regWriteE;
    logic       memToRegE;
    logic [4:0] writeRegE;
    logic       memToRegM;
    logic [4:0] writeRegM;
    logic       mduStartE;
    logic       mduIsDivE;
    logic       memReqM;
    logic       dmemReadyM;
    logic       stallF;
    logic       stallD;
    logic       stallE;
    logic       stallM;
    logic       flushD;
    logic       flushE;
    logic       mduBusy;
    logic       memTimeout;

    int vecCount;
    int missCount;

    // Reference model state: cycles of HI/LO occupancy left, length of the
    // current dmem wait run, and the sticky timeout flag.
    int   busyLeft;
    int   waitRun;
    logic timedOut;

    hazard_ctrl #(
        .MUL_LAT     (MUL_LAT),
        .DIV_LAT     (DIV_LAT),
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rsD        (rsD),
        .rtD        (rtD),
        .useRsD     (useRsD),
        .useRtD     (useRtD),
        .branchD    (branchD),
        .takenD     (takenD),
        .hiloUseD   (hiloUseD),
        .regWriteE  (regWriteE),
        .memToRegE  (memToRegE),
        .writeRegE  (writeRegE),
        .memToRegM  (memToRegM),
        .writeRegM  (writeRegM),
        .mduStartE  (mduStartE),
        .mduIsDivE  (mduIsDivE),
        .memReqM    (memReqM),
        .dmemReadyM (dmemReadyM),
        .stallF     (stallF),
        .stallD     (stallD),
        .stallE     (stallE),
        .stallM     (stallM),
        .flushD     (flushD),
        .flushE     (flushE),
        .mduBusy    (mduBusy),
        .memTimeout (memTimeout)
    );

    // Clock: 10 time-unit period, rising edges at 5, 15, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Does the instruction in D read register r?
    function automatic logic readsReg(input logic [4:0] r);
        return (r != 5'd0) && ((useRsD && rsD == r) || (useRtD && rtD == r));
    endfunction

    // Expected {stallF,stallD,stallE,stallM,flushD,flushE,mduBusy,memTimeout}.
    function automatic logic [7:0] modelOut();
        logic hazard;
        logic busy;
        busy = (busyLeft > 0);
        if (!rst)
            return {4'b0000, 2'b11, busy, timedOut};
        if (memReqM && !dmemReadyM)
            return {4'b1111, 2'b00, busy, timedOut};
        hazard = (memToRegE && regWriteE && readsReg(writeRegE)) ||
                 (branchD && ((regWriteE && readsReg(writeRegE)) ||
                              (memToRegM && readsReg(writeRegM)))) ||
                 (hiloUseD && (busy || mduStartE));
        if (hazard)
            return {4'b1100, 2'b01, busy, timedOut};
        return {4'b0000, takenD, 1'b0, busy, timedOut};
    endfunction

    // Advance the reference model across one rising edge.
    task automatic modelEdge();
        logic waiting;
        waiting = memReqM && !dmemReadyM;
        if (!rst) begin
            busyLeft = 0;
            waitRun  = 0;
            timedOut = 1'b0;
        end else begin
            if (waitRun >= MEM_TIMEOUT) timedOut = 1'b1;
            waitRun = waiting ? waitRun + 1 : 0;
            if (mduStartE && !waiting)
                busyLeft = mduIsDivE ? DIV_LAT : MUL_LAT;
            else if (busyLeft > 0)
                busyLeft = busyLeft - 1;
        end
    endtask

    // Compare outputs mid-cycle, then clock once (inputs already applied).
    task automatic step(input string tag);
        logic [7:0] got;
        logic [7:0] exp;
        #1;
        exp = modelOut();
        got = {stallF, stallD, stallE, stallM, flushD, flushE, mduBusy, memTimeout};
        vecCount++;
        assert (got === exp) else begin
            missCount++;
            $error("FAIL %s: observed %b expected %b (sFDEM fDE busy to)", tag, got, exp);
        end
        @(posedge clk);
        modelEdge();
        @(negedge clk);
    endtask

    task automatic setIdle();
        rsD = 5'd0; rtD = 5'd0; useRsD = 1'b0; useRtD = 1'b0;
        branchD = 1'b0; takenD = 1'b0; hiloUseD = 1'b0;
        regWriteE = 1'b0; memToRegE = 1'b0; writeRegE = 5'd0;
        memToRegM = 1'b0; writeRegM = 5'd0;
        mduStartE = 1'b0; mduIsDivE = 1'b0;
        memReqM = 1'b0; dmemReadyM = 1'b1;
    endtask

    task automatic setLoadUse(input logic [4:0] r);
        memToRegE = 1'b1; regWriteE = 1'b1; writeRegE = r;
        useRsD = 1'b1; rsD = r;
    endtask

    task automatic randomInputs();
        rsD        = 5'($urandom_range(0, 3));
        rtD        = 5'($urandom_range(0, 3));
        useRsD     = 1'($urandom_range(0, 1));
        useRtD     = 1'($urandom_range(0, 1));
        branchD    = ($urandom_range(0, 3) == 0);
        takenD     = 1'($urandom_range(0, 1));
        hiloUseD   = ($urandom_range(0, 4) == 0);
        regWriteE  = 1'($urandom_range(0, 1));
        memToRegE  = ($urandom_range(0, 2) == 0);
        writeRegE  = 5'($urandom_range(0, 3));
        memToRegM  = ($urandom_range(0, 2) == 0);
        writeRegM  = 5'($urandom_range(0, 3));
        mduStartE  = ($urandom_range(0, 15) == 0);
        mduIsDivE  = ($urandom_range(0, 3) == 0);
        memReqM    = 1'($urandom_range(0, 1));
        dmemReadyM = ($urandom_range(0, 4) != 0);
        rst        = ($urandom_range(0, 99) != 0);
    endtask

    initial begin
        vecCount  = 0;
        missCount = 0;
        busyLeft  = 0;
        waitRun   = 0;
        timedOut  = 1'b0;
        setIdle();
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        // Reset state: bubbles in D/E, no stalls, nothing busy.
        step("reset0");
        step("reset1");
        rst = 1'b1;
        step("idle");

        // Load-use on $2: one bubble, then clear.
        setLoadUse(5'd2);
        step("loadUse");
        setIdle(); useRsD = 1'b1; rsD = 5'd2;
        step("loadUseAfter");

        // Load to $0 read by D: no hazard.
        setIdle(); setLoadUse(5'd0);
        step("loadZero");

        // Branch on $3 written by ALU op in E, then resolves taken.
        setIdle();
        branchD = 1'b1; takenD = 1'b1; useRsD = 1'b1; rsD = 5'd3;
        regWriteE = 1'b1; writeRegE = 5'd3;
        step("branchStall");
        regWriteE = 1'b0; writeRegE = 5'd0;
        step("branchTaken");

        // Branch on $4 loaded in M.
        setIdle();
        branchD = 1'b1; useRtD = 1'b1; rtD = 5'd4;
        memToRegM = 1'b1; writeRegM = 5'd4;
        step("branchLoadM");

        // DIV issue with MFLO waiting in D, then MULT likewise.
        for (int k = 0; k < 2; k++) begin
            setIdle();
            mduStartE = 1'b1; mduIsDivE = (k == 0); hiloUseD = 1'b1;
            step(k == 0 ? "divIssue" : "mulIssue");
            mduStartE = 1'b0;
            for (int i = 0; i < (k == 0 ? DIV_LAT : MUL_LAT) + 2; i++)
                step(k == 0 ? "divBusy" : "mulBusy");
        end

        // Memory wait during load-use freezes everything, then bubble resumes.
        setIdle(); setLoadUse(5'd5);
        memReqM = 1'b1; dmemReadyM = 1'b0;
        for (int i = 0; i < 3; i++) step("memFreeze");
        dmemReadyM = 1'b1;
        step("memResume");

        // Long dmem wait trips the sticky timeout.
        setIdle();
        memReqM = 1'b1; dmemReadyM = 1'b0;
        for (int i = 0; i < MEM_TIMEOUT + 5; i++) step("memWait");
        dmemReadyM = 1'b1;
        for (int i = 0; i < 3; i++) step("timeoutSticky");

        // DIV issue then reset mid-operation.
        setIdle();
        mduStartE = 1'b1; mduIsDivE = 1'b1;
        step("divStart");
        mduStartE = 1'b0;
        for (int i = 0; i < 5; i++) step("divRun");
        rst = 1'b0;
        step("resetMidDiv");
        rst = 1'b1; hiloUseD = 1'b1;
        step("afterReset");

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            randomInputs();
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
